// File: rtl/keypad_emulator.sv
// keypad_emulator: scripted 4x4 matrix keypad answering a row-scanning scanner,
// with reproducible LFSR contact bounce around each press and release.
module keypad_emulator #(
  parameter int BOUNCE_CYCLES = 8,
  parameter int HOLD_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        r,
  input  logic              start,
  input  logic [1:0]        keyRow,
  input  logic [1:0]        keyCol,
  input  logic [HOLD_W-1:0] holdCycles,
  output logic              c0,
  output logic              c1,
  output logic              c2,
  output logic              c3,
  output logic              keyDown,
  output logic              busy,
  output logic              done
);

  localparam int BW = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BOUNCE_LOAD = BW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [3:0] LFSR_SEED = 4'b1001;
  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE} state_t;

  state_t            state, stateNext;
  logic [BW-1:0]     bounceCnt, bounceCntNext;
  logic [HOLD_W-1:0] holdCnt, holdCntNext;
  logic [HOLD_W-1:0] holdLoad, holdLoadNext;
  logic [1:0]        rowLatched, rowNext;
  logic [1:0]        colLatched, colNext;
  logic [3:0]        lfsr, lfsrNext;
  logic              doneNext;
  logic              contact;
  logic [3:0]        colVec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bounceCnt  <= '0;
      holdCnt    <= '0;
      holdLoad   <= '0;
      rowLatched <= 2'd0;
      colLatched <= 2'd0;
      lfsr       <= LFSR_SEED;
      done       <= 1'b0;
    end else begin
      state      <= stateNext;
      bounceCnt  <= bounceCntNext;
      holdCnt    <= holdCntNext;
      holdLoad   <= holdLoadNext;
      rowLatched <= rowNext;
      colLatched <= colNext;
      lfsr       <= lfsrNext;
      done       <= doneNext;
    end
  end

  // Counters hold "remaining cycles minus one", so a hold of all ones never wraps.
  always_comb begin
    stateNext     = state;
    bounceCntNext = bounceCnt;
    holdCntNext   = holdCnt;
    holdLoadNext  = holdLoad;
    rowNext       = rowLatched;
    colNext       = colLatched;
    lfsrNext      = lfsr;
    doneNext      = 1'b0;
    contact       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          rowNext      = keyRow;
          colNext      = keyCol;
          holdLoadNext = (holdCycles == '0) ? '0 : holdCycles - HOLD_W'(1);
          if (HAS_BOUNCE) begin
            stateNext     = PRESS_BOUNCE;
            bounceCntNext = BOUNCE_LOAD;
          end else begin
            stateNext   = HOLD;
            holdCntNext = holdLoadNext;
          end
        end
      end
      PRESS_BOUNCE: begin
        contact  = lfsr[0];
        lfsrNext = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        if (bounceCnt == '0) begin
          stateNext   = HOLD;
          holdCntNext = holdLoad;
        end else begin
          bounceCntNext = bounceCnt - BW'(1);
        end
      end
      HOLD: begin
        contact = 1'b1;
        if (holdCnt == '0) begin
          if (HAS_BOUNCE) begin
            stateNext     = RELEASE_BOUNCE;
            bounceCntNext = BOUNCE_LOAD;
          end else begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end
        end else begin
          holdCntNext = holdCnt - HOLD_W'(1);
        end
      end
      RELEASE_BOUNCE: begin
        contact  = lfsr[0];
        lfsrNext = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        if (bounceCnt == '0) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end else begin
          bounceCntNext = bounceCnt - BW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Single-key model: only the latched column answers, and only while its row is driven.
  always_comb begin
    colVec = 4'b0000;
    if (contact && r[rowLatched]) colVec[colLatched] = 1'b1;
  end

  assign c0      = colVec[0];
  assign c1      = colVec[1];
  assign c2      = colVec[2];
  assign c3      = colVec[3];
  assign keyDown = contact;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: drives a bouncing (8-cycle) and a bounce-free keypad side by side
// and compares every cycle against a phase-queue reference model.
module tb_keypad_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  r;
  logic        start8, start0;
  logic [1:0]  keyRow, keyCol;
  logic [15:0] hold8;
  logic [7:0]  hold0;
  logic        c0a, c1a, c2a, c3a, keyDownA, busyA, doneA;
  logic        c0b, c1b, c2b, c3b, keyDownB, busyB, doneB;

  int checks = 0;
  int errors = 0;

  // Index 0 models the 8-cycle-bounce keypad, index 1 the bounce-free one.
  // Each queue entry is one remaining busy cycle: 0 = bounce cycle, 1 = hold cycle.
  bit       expQ[2][$];
  bit [3:0] mLfsr[2];
  int       mRow[2];
  int       mCol[2];
  bit       mDone[2];
  int       bounceLen[2] = '{8, 0};

  keypad_emulator #(.BOUNCE_CYCLES(8), .HOLD_W(16)) dut8 (
    .clk(clk), .reset(reset), .r(r), .start(start8), .keyRow(keyRow), .keyCol(keyCol),
    .holdCycles(hold8), .c0(c0a), .c1(c1a), .c2(c2a), .c3(c3a),
    .keyDown(keyDownA), .busy(busyA), .done(doneA)
  );

  keypad_emulator #(.BOUNCE_CYCLES(0), .HOLD_W(8)) dut0 (
    .clk(clk), .reset(reset), .r(r), .start(start0), .keyRow(keyRow), .keyCol(keyCol),
    .holdCycles(hold0), .c0(c0b), .c1(c1b), .c2(c2b), .c3(c3b),
    .keyDown(keyDownB), .busy(busyB), .done(doneB)
  );

  always #10 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      expQ[i].delete();
      mLfsr[i] = 4'b1001;
      mRow[i]  = 0;
      mCol[i]  = 0;
      mDone[i] = 1'b0;
    end
  endtask

  task automatic modelEdge(int i, bit st, int row, int col, int hold);
    int holdEff;
    mDone[i] = 1'b0;
    if (expQ[i].size() > 0) begin
      if (expQ[i][0] == 1'b0) mLfsr[i] = {mLfsr[i][2:0], mLfsr[i][3] ^ mLfsr[i][2]};
      expQ[i].delete(0);
      if (expQ[i].size() == 0) mDone[i] = 1'b1;
    end else if (st) begin
      mRow[i] = row;
      mCol[i] = col;
      holdEff = (hold == 0) ? 1 : hold;
      for (int k = 0; k < bounceLen[i]; k++) expQ[i].push_back(1'b0);
      for (int k = 0; k < holdEff; k++) expQ[i].push_back(1'b1);
      for (int k = 0; k < bounceLen[i]; k++) expQ[i].push_back(1'b0);
    end
  endtask

  task automatic checkValue(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    for (int i = 0; i < 2; i++) begin
      bit         expContact;
      logic [3:0] expC;
      logic [3:0] obsC;
      string      who;
      expContact = 1'b0;
      if (expQ[i].size() > 0) expContact = expQ[i][0] ? 1'b1 : mLfsr[i][0];
      expC = 4'b0000;
      if (expContact && r[mRow[i]]) expC[mCol[i]] = 1'b1;
      who  = (i == 0) ? "b8" : "b0";
      obsC = (i == 0) ? {c3a, c2a, c1a, c0a} : {c3b, c2b, c1b, c0b};
      checkValue({tag, "/", who, "/c"}, obsC, expC);
      checkValue({tag, "/", who, "/keyDown"}, {3'b0, (i == 0) ? keyDownA : keyDownB}, {3'b0, expContact});
      checkValue({tag, "/", who, "/busy"}, {3'b0, (i == 0) ? busyA : busyB}, {3'b0, expQ[i].size() > 0});
      checkValue({tag, "/", who, "/done"}, {3'b0, (i == 0) ? doneA : doneB}, {3'b0, mDone[i]});
    end
  endtask

  task automatic applyStimulus(bit s8, bit s0, int row, int col, int h8, int h0);
    start8 = s8;
    start0 = s0;
    keyRow = 2'(row);
    keyCol = 2'(col);
    hold8  = 16'(h8);
    hold0  = 8'(h0);
  endtask

  // One clock: advance the model on the inputs in force, then check after the edge and
  // again after a fresh random r to exercise the combinational row-to-column path.
  task automatic cycle(string tag);
    modelEdge(0, start8, int'(keyRow), int'(keyCol), int'(hold8));
    modelEdge(1, start0, int'(keyRow), int'(keyCol), int'(hold0));
    @(posedge clk);
    #1;
    checkOutput(tag);
    r = 4'($urandom_range(0, 15));
    #1;
    checkOutput({tag, "+r"});
  endtask

  task automatic runCycles(string tag, int n);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  initial begin
    reset = 1'b1;
    r     = 4'b0000;
    applyStimulus(0, 0, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    #2 reset = 1'b0;

    for (int k = 0; k < 20; k++) begin
      r = 4'b0001 << (k % 4);
      cycle("idle");
    end

    applyStimulus(0, 1, 2, 1, 0, 5);
    cycle("b0-start");
    applyStimulus(0, 0, 2, 1, 0, 5);
    runCycles("b0-hold5", 9);

    applyStimulus(1, 0, 1, 3, 10, 0);
    cycle("b8-start");
    applyStimulus(0, 0, 1, 3, 10, 0);
    runCycles("b8-hold10", 30);

    applyStimulus(1, 1, 0, 2, 0, 0);
    cycle("hold0-start");
    applyStimulus(0, 0, 0, 2, 0, 0);
    cycle("hold0");
    applyStimulus(1, 1, 3, 1, 7, 7);
    runCycles("restart-busy", 3);
    applyStimulus(0, 0, 3, 1, 7, 7);
    runCycles("hold0-tail", 25);

    applyStimulus(0, 1, 1, 1, 0, 2);
    runCycles("start-in-done", 12);
    applyStimulus(0, 0, 1, 1, 0, 2);
    runCycles("start-in-done-tail", 4);

    for (int n = 0; n < 6; n++) begin
      applyStimulus(1, 1, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 20), $urandom_range(0, 20));
      cycle("rand-start");
      start8 = 1'b0;
      start0 = 1'b0;
      runCycles("rand", 40);
    end

    applyStimulus(1, 0, 3, 3, 20, 0);
    cycle("b8-r3c3");
    applyStimulus(0, 0, 3, 3, 20, 0);
    runCycles("b8-r3c3", 11);
    r = 4'b1000;
    #1;
    checkOutput("hold-r3");
    checkValue("hold-r3/c3", {3'b0, c3a}, 4'b0001);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("midreset");
    #2 reset = 1'b0;
    runCycles("post-reset", 3);

    applyStimulus(1, 0, 3, 3, 4, 0);
    cycle("replay");
    applyStimulus(0, 0, 3, 3, 4, 0);
    runCycles("replay", 24);

    applyStimulus(0, 1, 2, 0, 0, 255);
    cycle("maxhold");
    applyStimulus(0, 0, 2, 0, 0, 255);
    runCycles("maxhold", 258);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
